// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU for the multicycle datapath.
// Single-cycle ops register their result on the accept edge.
// MUL/MULHU run through an iterative shift-add unit that consumes one
// multiplier bit per cycle, LSB first. The result is written one edge
// after the final iteration.
module alu_seq #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1,
    parameter int SHW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MULT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_SUB   = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_NE    = 4'b0110;
    localparam logic [3:0] OP_SRA   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SLT   = 4'b1001;
    localparam logic [3:0] OP_SLTU  = 4'b1010;
    localparam logic [3:0] OP_MUL   = 4'b1011;
    localparam logic [3:0] OP_MULHU = 4'b1100;

    // Counter reaches WIDTH after the last multiplier bit has been consumed.
    localparam logic [SHW:0] CNT_LAST = (SHW + 1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};

    // Single-cycle result; mul codes fall to the default here and never
    // reach this path when the multiplier is built in.
    function automatic logic [WIDTH-1:0] alu_calc(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [3:0]       op
    );
        logic [SHW-1:0] sh;
        sh = y[SHW-1:0];
        case (op)
            OP_ADD:  alu_calc = x + y;
            OP_SUB:  alu_calc = x - y;
            OP_AND:  alu_calc = x & y;
            OP_OR:   alu_calc = x | y;
            OP_XOR:  alu_calc = x ^ y;
            OP_SLL:  alu_calc = x << sh;
            OP_SRL:  alu_calc = x >> sh;
            OP_SRA:  alu_calc = $unsigned($signed(x) >>> sh);
            OP_NE:   alu_calc = {{(WIDTH-1){1'b0}}, (x != y)};
            OP_SLT:  alu_calc = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            OP_SLTU: alu_calc = {{(WIDTH-1){1'b0}}, (x < y)};
            default: alu_calc = {WIDTH{1'b0}};
        endcase
    endfunction

    state_t             r_state;
    state_t             w_state_next;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_hi;
    logic [SHW:0]       r_cnt;
    logic               w_is_mul;
    logic [WIDTH-1:0]   w_alu;
    logic [WIDTH-1:0]   w_mul_res;

    assign w_is_mul  = (MUL_EN != 0) && ((ALUControl == OP_MUL) || (ALUControl == OP_MULHU));
    assign w_alu     = alu_calc(a, b, ALUControl);
    assign w_mul_res = r_hi ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic for the request / multiply / hold-result sequence.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_state_next = w_is_mul ? MULT : DONE;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MULT: begin
                if (r_cnt == CNT_LAST) begin
                    w_state_next = DONE;
                end else begin
                    w_state_next = MULT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end else begin
                    w_state_next = DONE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath: result/zero registers and the shift-add multiplier.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ALUResult <= {WIDTH{1'b0}};
            zero      <= 1'b0;
            r_acc     <= {(2*WIDTH){1'b0}};
            r_mcand   <= {(2*WIDTH){1'b0}};
            r_mplier  <= {WIDTH{1'b0}};
            r_hi      <= 1'b0;
            r_cnt     <= {(SHW+1){1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_mul) begin
                            r_mcand  <= {{WIDTH{1'b0}}, a};
                            r_mplier <= b;
                            r_hi     <= (ALUControl == OP_MULHU);
                            r_acc    <= {(2*WIDTH){1'b0}};
                            r_cnt    <= {(SHW+1){1'b0}};
                        end else begin
                            ALUResult <= w_alu;
                            zero      <= (w_alu == {WIDTH{1'b0}});
                        end
                    end
                end
                MULT: begin
                    if (r_cnt == CNT_LAST) begin
                        ALUResult <= w_mul_res;
                        zero      <= (w_mul_res == {WIDTH{1'b0}});
                    end else begin
                        // r_mcand holds a << counter; r_mplier[0] is b[counter].
                        if (r_mplier[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_cnt    <= r_cnt + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
